// File: rtl/fir_lpf_2mult_ctrl_pkg.sv
// rtl/fir_lpf_2mult_ctrl_pkg.sv - FIR sequencer state type plus rounding and saturation helpers
package fir_lpf_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_e;

   // Working width for round/clamp math; comfortably wider than any accumulator used here
   localparam int MathWidth = 64;

   // Half an output LSB for a Q1.(coeff_width-1) product sum: added before the shift to round half up
   function automatic logic signed [MathWidth-1:0] round_const(input int coeff_width);
      return 64'sd1 <<< (coeff_width - 2);
   endfunction

   // Clamp a shifted accumulator value into the signed data_width output range
   function automatic logic signed [MathWidth-1:0] sat_data(input logic signed [MathWidth-1:0] v,
                                                            input int data_width);
      logic signed [MathWidth-1:0] hi;
      logic signed [MathWidth-1:0] lo;
      hi = (64'sd1 <<< (data_width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (data_width - 1));
      if (v > hi) return hi;
      else if (v < lo) return lo;
      else return v;
   endfunction

endpackage

// File: rtl/fir_lpf_2mult_ctrl_if.sv
// rtl/fir_lpf_2mult_ctrl_if.sv - sample stream, coefficient LUT port and output stream of the FIR sequencer
interface fir_lpf_2mult_ctrl_if #(
   parameter int DataWidth  = 16,
   parameter int CoeffWidth = 16,
   parameter int AddrWidth  = 6
);
   logic                         in_valid_i;
   logic                         in_ready_o;
   logic signed [DataWidth-1:0]  in_data_i;
   logic                         ren_o;
   logic [AddrWidth-1:0]         addr1_o;
   logic [AddrWidth-1:0]         addr2_o;
   logic signed [CoeffWidth-1:0] coeff1_i;
   logic signed [CoeffWidth-1:0] coeff2_i;
   logic                         out_valid_o;
   logic                         out_ready_i;
   logic signed [DataWidth-1:0]  out_data_o;

   // filter side: signal suffixes follow the filter's point of view
   modport slave (
      input  in_valid_i, in_data_i, coeff1_i, coeff2_i, out_ready_i,
      output in_ready_o, ren_o, addr1_o, addr2_o, out_valid_o, out_data_o
   );

   // environment side: sample source, LUT and downstream sink
   modport master (
      output in_valid_i, in_data_i, coeff1_i, coeff2_i, out_ready_i,
      input  in_ready_o, ren_o, addr1_o, addr2_o, out_valid_o, out_data_o
   );
endinterface

// File: rtl/fir_lpf_2mult_ctrl_delay_line.sv
// rtl/fir_lpf_2mult_ctrl_delay_line.sv - circular sample history with two age-addressed read ports
module fir_delay_line #(
   parameter int DataWidth = 16,
   parameter int Taps      = 38,
   parameter int AddrWidth = $clog2(Taps)
) (
   input  logic                        clk_i,
   input  logic                        clr_i,
   input  logic                        we_i,
   input  logic signed [DataWidth-1:0] wdata_i,
   input  logic [AddrWidth-1:0]        age1_i,
   input  logic [AddrWidth-1:0]        age2_i,
   output logic signed [DataWidth-1:0] rdata1_o,
   output logic signed [DataWidth-1:0] rdata2_o
);

   logic signed [DataWidth-1:0] mem_q [Taps];
   logic [AddrWidth-1:0]        wptr_q;

   // Age 0 is the most recent write, which sits one slot behind the write pointer
   function automatic logic [AddrWidth-1:0] slot_of(input logic [AddrWidth-1:0] wptr,
                                                    input logic [AddrWidth-1:0] age);
      int idx;
      idx = int'(wptr) + Taps - 1 - int'(age);
      if (idx >= Taps) idx = idx - Taps;
      return idx[AddrWidth-1:0];
   endfunction

   // Ring write with wrapping pointer; clear wipes the whole history
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         wptr_q <= '0;
         for (int i = 0; i < Taps; i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[wptr_q] <= wdata_i;
         wptr_q        <= (wptr_q == AddrWidth'(Taps - 1)) ? '0 : wptr_q + 1'b1;
      end
   end

   assign rdata1_o = mem_q[slot_of(wptr_q, age1_i)];
   assign rdata2_o = mem_q[slot_of(wptr_q, age2_i)];

endmodule

// File: rtl/fir_lpf_2mult_ctrl.sv
// rtl/fir_lpf_2mult_ctrl.sv - two-MAC-per-cycle FIR low-pass sequencer; FIR_LPF_SAT_FLAG_EN adds sticky sat_o
module fir_lpf_2mult_ctrl
   import fir_lpf_pkg::*;
#(
   parameter int DataWidth  = 16,
   parameter int CoeffWidth = 16,
   parameter int Taps       = 38,
   parameter int AddrWidth  = $clog2(Taps),
   parameter int AccWidth   = DataWidth + CoeffWidth + $clog2(Taps)
) (
   input  logic clk_i,
   input  logic rst_i,
`ifdef FIR_LPF_SAT_FLAG_EN
   output logic sat_o,
`endif
   fir_lpf_2mult_ctrl_if.slave fir_if
);

   localparam int                   NumMac  = (Taps + 1) / 2;
   localparam logic [AddrWidth-1:0] LastJ   = AddrWidth'(NumMac - 1);
   localparam bit                   OddTaps = (Taps % 2) == 1;

   state_e                      state_q, state_d;
   logic [AddrWidth-1:0]        j_q, j_d;
   logic [AddrWidth-1:0]        addr1_q, addr1_d, addr2_q, addr2_d;
   logic                        ren_q, ren_d, acc_en_q;
   logic signed [AccWidth-1:0]  acc_q, acc_d, prod1, prod2;
   logic signed [DataWidth-1:0] s1_q, s1_d, s2_q, s2_d;
   logic signed [DataWidth-1:0] out_data_q, out_data_d;
   logic signed [MathWidth-1:0] acc_wide, rounded;
   logic [AddrWidth-1:0]        age1, age2;
   logic signed [DataWidth-1:0] rd1, rd2;
   logic                        dl_we, last_odd;

   // Negative addresses only arise for the missing partner tap of an odd-length filter
   function automatic logic [AddrWidth-1:0] lut_addr(input int a);
      return (a < 0) ? '0 : a[AddrWidth-1:0];
   endfunction

   fir_delay_line #(
      .DataWidth (DataWidth),
      .Taps      (Taps),
      .AddrWidth (AddrWidth)
   ) u_delay_line (
      .clk_i    (clk_i),
      .clr_i    (rst_i),
      .we_i     (dl_we),
      .wdata_i  (fir_if.in_data_i),
      .age1_i   (age1),
      .age2_i   (age2),
      .rdata1_o (rd1),
      .rdata2_o (rd2)
   );

   // Fetch the two samples matching the addresses currently on the LUT port
   always_comb begin
      last_odd = OddTaps && (j_q == LastJ);
      age1     = lut_addr(2 * int'(j_q));
      age2     = last_odd ? '0 : lut_addr(2 * int'(j_q) + 1);
      s1_d     = rd1;
      s2_d     = last_odd ? '0 : rd2;
      prod1    = {{(AccWidth-CoeffWidth){fir_if.coeff1_i[CoeffWidth-1]}}, fir_if.coeff1_i}
               * {{(AccWidth-DataWidth){s1_q[DataWidth-1]}}, s1_q};
      prod2    = {{(AccWidth-CoeffWidth){fir_if.coeff2_i[CoeffWidth-1]}}, fir_if.coeff2_i}
               * {{(AccWidth-DataWidth){s2_q[DataWidth-1]}}, s2_q};
   end

   // Next state, address issue, accumulation and output rounding
   always_comb begin
      state_d    = state_q;
      j_d        = j_q;
      ren_d      = 1'b0;
      addr1_d    = '0;
      addr2_d    = '0;
      dl_we      = 1'b0;
      out_data_d = out_data_q;
      acc_d      = acc_q;
      if (acc_en_q) acc_d = acc_q + prod1 + prod2;
      acc_wide   = {{(MathWidth-AccWidth){acc_d[AccWidth-1]}}, acc_d};
      rounded    = (acc_wide + round_const(CoeffWidth)) >>> (CoeffWidth - 1);
      case (state_q)
         IDLE: begin
            if (fir_if.in_valid_i) begin
               dl_we   = 1'b1;
               acc_d   = '0;
               j_d     = '0;
               ren_d   = 1'b1;
               addr1_d = lut_addr(Taps - 1);
               addr2_d = lut_addr(Taps - 2);
               state_d = RUN;
            end
         end
         RUN: begin
            if (j_q == LastJ) begin
               state_d = DRAIN;
            end else begin
               j_d     = j_q + 1'b1;
               ren_d   = 1'b1;
               addr1_d = lut_addr(Taps - 3 - 2 * int'(j_q));
               addr2_d = lut_addr(Taps - 4 - 2 * int'(j_q));
            end
         end
         DRAIN: begin
            out_data_d = DataWidth'(sat_data(rounded, DataWidth));
            state_d    = OUT;
         end
         OUT: begin
            if (fir_if.out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, issue and datapath registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         j_q        <= '0;
         ren_q      <= 1'b0;
         addr1_q    <= '0;
         addr2_q    <= '0;
         acc_en_q   <= 1'b0;
         acc_q      <= '0;
         s1_q       <= '0;
         s2_q       <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         j_q        <= j_d;
         ren_q      <= ren_d;
         addr1_q    <= addr1_d;
         addr2_q    <= addr2_d;
         acc_en_q   <= ren_q;
         acc_q      <= acc_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         out_data_q <= out_data_d;
      end
   end

`ifdef FIR_LPF_SAT_FLAG_EN
   logic sat_q, sat_d;

   // Sticky flag: latches whenever the clamp alters the rounded result
   always_comb begin
      sat_d = sat_q;
      if (state_q == DRAIN && sat_data(rounded, DataWidth) != rounded) sat_d = 1'b1;
   end

   // Flag register, cleared only by reset
   always_ff @(posedge clk_i) begin
      if (rst_i) sat_q <= 1'b0;
      else       sat_q <= sat_d;
   end

   assign sat_o = sat_q;
`endif

   assign fir_if.in_ready_o  = (state_q == IDLE);
   assign fir_if.out_valid_o = (state_q == OUT);
   assign fir_if.out_data_o  = out_data_q;
   assign fir_if.ren_o       = ren_q;
   assign fir_if.addr1_o     = addr1_q;
   assign fir_if.addr2_o     = addr2_q;

endmodule
